hdr_bit_frm_counter: RTL and testbench

Shared bit/frame counter for the HDR-DDR datapath. It is driven by the bit-count and frame-count enables that the DDR-mode and CCC sub-engines produce, after the HDR engine's `*_cnt_en_sel` muxes. It tracks the position inside each 20-bit DDR word (2 preamble, 16 data, 2 parity) on both SCL edges. It also counts down the number of words in the transfer, and reports word boundaries, last word and transfer completion back to the active sub-engine.

---
 rtl/hdr_bit_frm_counter.sv | 127 ++++++++++++
 tb/tb_hdr_bit_frm_counter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdr_bit_frm_counter.sv
// Shared HDR-DDR bit/frame counter: tracks bit position inside each
// DDR word on both SCL edges and counts down the words of a transfer.
module hdr_bit_frm_counter #(
  parameter int WORD_BITS = 20,
  parameter int FRM_W     = 16
) (
  input  logic             i_sys_clk,
  input  logic             i_sys_rst,
  input  logic             i_bit_cnt_en,
  input  logic             i_frm_cnt_en,
  input  logic             i_scl_pos_edge,
  input  logic             i_scl_neg_edge,
  input  logic [FRM_W-1:0] i_frm_len,
  output logic [4:0]       o_bit_cnt,
  output logic             o_word_done,
  output logic [FRM_W-1:0] o_frm_cnt,
  output logic             o_last_frm,
  output logic             o_frm_done,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  localparam logic [4:0] LP_TOP = 5'(WORD_BITS - 1);
  localparam logic [FRM_W-1:0] LP_ONE = FRM_W'(1);

  state_t           r_state;
  logic             r_bit_en_d;
  logic             r_frm_en_d;
  logic [4:0]       r_bit_cnt;
  logic [FRM_W-1:0] r_frm_cnt;
  logic             r_word_done;
  logic             r_frm_done;
  logic             r_busy;

  logic w_edge;
  logic w_bit_rise;
  logic w_frm_rise;
  logic w_word_end;

  assign w_edge     = i_scl_pos_edge | i_scl_neg_edge;
  assign w_bit_rise = i_bit_cnt_en & ~r_bit_en_d;
  assign w_frm_rise = i_frm_cnt_en & ~r_frm_en_d;
  assign w_word_end = w_edge && (r_bit_cnt == 5'd0);

  // Enable history resets high so an enable held through reset
  // must drop and rise again before counting resumes.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_state     <= IDLE;
      r_bit_en_d  <= 1'b1;
      r_frm_en_d  <= 1'b0;
      r_bit_cnt   <= LP_TOP;
      r_frm_cnt   <= '0;
      r_word_done <= 1'b0;
      r_frm_done  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_bit_en_d  <= i_bit_cnt_en;
      r_frm_en_d  <= i_frm_cnt_en;
      r_word_done <= 1'b0;
      r_frm_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_bit_rise) begin
            r_state   <= RUN;
            r_busy    <= 1'b1;
            r_bit_cnt <= LP_TOP;
            if (i_frm_cnt_en) r_frm_cnt <= i_frm_len;
          end
        end
        RUN: begin
          if (!i_bit_cnt_en) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_bit_cnt <= LP_TOP;
          end else begin
            if (w_edge) begin
              if (r_bit_cnt != 5'd0) begin
                r_bit_cnt <= r_bit_cnt - 5'd1;
              end else begin
                r_bit_cnt   <= LP_TOP;
                r_word_done <= 1'b1;
              end
            end
            // A CCC -> DDR handover reloads the word count mid-window.
            if (w_frm_rise) begin
              r_frm_cnt <= i_frm_len;
            end else if (w_word_end && i_frm_cnt_en) begin
              if (r_frm_cnt > LP_ONE) begin
                r_frm_cnt <= r_frm_cnt - LP_ONE;
              end else begin
                r_frm_cnt  <= '0;
                r_frm_done <= 1'b1;
                r_state    <= HOLD;
              end
            end
          end
        end
        HOLD: begin
          r_bit_cnt <= LP_TOP;
          r_frm_cnt <= '0;
          if (!i_bit_cnt_en) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_bit_cnt   = r_bit_cnt;
  assign o_word_done = r_word_done;
  assign o_frm_cnt   = r_frm_cnt;
  assign o_frm_done  = r_frm_done;
  assign o_busy      = r_busy;
  assign o_last_frm  = (r_state != IDLE) && (r_frm_cnt == LP_ONE);

endmodule

// File: tb/tb_hdr_bit_frm_counter.sv
// Directed bench for hdr_bit_frm_counter: reset, single/multi word,
// abort, corner strobes and bit-only counting.
module tb_hdr_bit_frm_counter;

  logic        clk;
  logic        rst;
  logic        bit_en;
  logic        frm_en;
  logic        pos;
  logic        neg;
  logic [15:0] frm_len;
  logic [4:0]  bit_cnt;
  logic        word_done;
  logic [15:0] frm_cnt;
  logic        last_frm;
  logic        frm_done;
  logic        busy;

  int checks;
  int failures;

  hdr_bit_frm_counter #(
    .WORD_BITS(20),
    .FRM_W(16)
  ) dut (
    .i_sys_clk     (clk),
    .i_sys_rst     (rst),
    .i_bit_cnt_en  (bit_en),
    .i_frm_cnt_en  (frm_en),
    .i_scl_pos_edge(pos),
    .i_scl_neg_edge(neg),
    .i_frm_len     (frm_len),
    .o_bit_cnt     (bit_cnt),
    .o_word_done   (word_done),
    .o_frm_cnt     (frm_cnt),
    .o_last_frm    (last_frm),
    .o_frm_done    (frm_done),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    bit_en = 1'b0;
    frm_en = 1'b0;
    pos = 1'b0;
    neg = 1'b0;
    tick();
    tick();
  endtask

  task automatic start(input logic [15:0] len, input logic fe);
    frm_len = len;
    frm_en = fe;
    bit_en = 1'b1;
    tick();
  endtask

  task automatic test_reset_init();
    checks++;
    if (bit_cnt !== 5'd19 || frm_cnt !== 16'd0 || busy !== 1'b0 ||
        word_done !== 1'b0 || frm_done !== 1'b0 || last_frm !== 1'b0) begin
      failures++;
      $display("FAIL reset_init bit=%0d frm=%0d busy=%b wd=%b fd=%b lf=%b want 19 0 0 0 0 0",
               bit_cnt, frm_cnt, busy, word_done, frm_done, last_frm);
    end
  endtask

  task automatic test_single_word();
    start(16'd1, 1'b1);
    checks++;
    if (busy !== 1'b1 || bit_cnt !== 5'd19 || frm_cnt !== 16'd1 ||
        last_frm !== 1'b1) begin
      failures++;
      $display("FAIL sw_load busy=%b bit=%0d frm=%0d lf=%b want 1 19 1 1",
               busy, bit_cnt, frm_cnt, last_frm);
    end
    for (int i = 0; i < 20; i++) begin
      pos = (i % 2 == 0);
      neg = (i % 2 == 1);
      tick();
      checks++;
      if (i < 19) begin
        if (bit_cnt !== 5'(18 - i) || word_done !== 1'b0 ||
            frm_done !== 1'b0 || last_frm !== 1'b1) begin
          failures++;
          $display("FAIL sw_step%0d bit=%0d wd=%b fd=%b lf=%b want %0d 0 0 1",
                   i, bit_cnt, word_done, frm_done, last_frm, 18 - i);
        end
      end else begin
        if (bit_cnt !== 5'd19 || word_done !== 1'b1 ||
            frm_done !== 1'b1 || frm_cnt !== 16'd0) begin
          failures++;
          $display("FAIL sw_end bit=%0d wd=%b fd=%b frm=%0d want 19 1 1 0",
                   bit_cnt, word_done, frm_done, frm_cnt);
        end
      end
    end
    pos = 1'b1;
    neg = 1'b0;
    tick();
    pos = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1 || bit_cnt !== 5'd19 || word_done !== 1'b0 ||
        frm_done !== 1'b0 || frm_cnt !== 16'd0) begin
      failures++;
      $display("FAIL sw_hold busy=%b bit=%0d wd=%b fd=%b frm=%0d want 1 19 0 0 0",
               busy, bit_cnt, word_done, frm_done, frm_cnt);
    end
    go_idle();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL sw_release busy=%b want 0", busy);
    end
  endtask

  task automatic test_multi_word();
    int nwd;
    int nfd;
    nwd = 0;
    nfd = 0;
    start(16'd3, 1'b1);
    for (int n = 1; n <= 60; n++) begin
      pos = 1'b1;
      tick();
      if (word_done === 1'b1) nwd++;
      if (frm_done === 1'b1) nfd++;
      if (n == 20) begin
        checks++;
        if (frm_cnt !== 16'd2 || last_frm !== 1'b0 || frm_done !== 1'b0) begin
          failures++;
          $display("FAIL mw_w1 frm=%0d lf=%b fd=%b want 2 0 0",
                   frm_cnt, last_frm, frm_done);
        end
      end
      if (n == 40) begin
        checks++;
        if (frm_cnt !== 16'd1 || last_frm !== 1'b1 || frm_done !== 1'b0) begin
          failures++;
          $display("FAIL mw_w2 frm=%0d lf=%b fd=%b want 1 1 0",
                   frm_cnt, last_frm, frm_done);
        end
      end
      if (n == 60) begin
        checks++;
        if (frm_cnt !== 16'd0 || last_frm !== 1'b0 || frm_done !== 1'b1 ||
            word_done !== 1'b1) begin
          failures++;
          $display("FAIL mw_w3 frm=%0d lf=%b fd=%b wd=%b want 0 0 1 1",
                   frm_cnt, last_frm, frm_done, word_done);
        end
      end
    end
    pos = 1'b0;
    checks++;
    if (nwd != 3 || nfd != 1) begin
      failures++;
      $display("FAIL mw_pulses word_done=%0d frm_done=%0d want 3 1", nwd, nfd);
    end
    go_idle();
  endtask

  task automatic test_abort();
    start(16'd5, 1'b1);
    for (int i = 0; i < 9; i++) begin
      neg = 1'b1;
      tick();
    end
    neg = 1'b0;
    checks++;
    if (bit_cnt !== 5'd10 || frm_cnt !== 16'd5) begin
      failures++;
      $display("FAIL ab_pre bit=%0d frm=%0d want 10 5", bit_cnt, frm_cnt);
    end
    bit_en = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || bit_cnt !== 5'd19 || word_done !== 1'b0 ||
        frm_cnt !== 16'd5 || last_frm !== 1'b0) begin
      failures++;
      $display("FAIL ab_post busy=%b bit=%0d wd=%b frm=%0d lf=%b want 0 19 0 5 0",
               busy, bit_cnt, word_done, frm_cnt, last_frm);
    end
    go_idle();
  endtask

  task automatic test_corner_strobes();
    pos = 1'b1;
    start(16'd2, 1'b1);
    checks++;
    if (bit_cnt !== 5'd19 || busy !== 1'b1) begin
      failures++;
      $display("FAIL cs_rise_strobe bit=%0d busy=%b want 19 1", bit_cnt, busy);
    end
    neg = 1'b1;
    tick();
    checks++;
    if (bit_cnt !== 5'd18) begin
      failures++;
      $display("FAIL cs_both1 bit=%0d want 18", bit_cnt);
    end
    tick();
    checks++;
    if (bit_cnt !== 5'd17) begin
      failures++;
      $display("FAIL cs_both2 bit=%0d want 17", bit_cnt);
    end
    go_idle();
    start(16'd0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      pos = 1'b1;
      neg = (i % 3 == 0);
      tick();
      if (i < 19) begin
        checks++;
        if (word_done !== 1'b0 || frm_done !== 1'b0) begin
          failures++;
          $display("FAIL len0_early%0d wd=%b fd=%b want 0 0",
                   i, word_done, frm_done);
        end
      end
    end
    pos = 1'b0;
    neg = 1'b0;
    checks++;
    if (word_done !== 1'b1 || frm_done !== 1'b1 || frm_cnt !== 16'd0) begin
      failures++;
      $display("FAIL len0_end wd=%b fd=%b frm=%0d want 1 1 0",
               word_done, frm_done, frm_cnt);
    end
    tick();
    checks++;
    if (frm_cnt !== 16'd0 || frm_done !== 1'b0) begin
      failures++;
      $display("FAIL len0_after frm=%0d fd=%b want 0 0", frm_cnt, frm_done);
    end
    go_idle();
  endtask

  task automatic test_bit_only();
    int nwd;
    int nfd;
    nwd = 0;
    nfd = 0;
    start(16'd4, 1'b1);
    frm_en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      pos = (i % 2 == 1);
      neg = (i % 2 == 0);
      tick();
      if (word_done === 1'b1) nwd++;
      if (frm_done === 1'b1) nfd++;
    end
    pos = 1'b0;
    neg = 1'b0;
    checks++;
    if (nwd != 2 || nfd != 0 || frm_cnt !== 16'd4 || busy !== 1'b1 ||
        bit_cnt !== 5'd19) begin
      failures++;
      $display("FAIL bo wd=%0d fd=%0d frm=%0d busy=%b bit=%0d want 2 0 4 1 19",
               nwd, nfd, frm_cnt, busy, bit_cnt);
    end
    frm_len = 16'd7;
    frm_en = 1'b1;
    tick();
    checks++;
    if (frm_cnt !== 16'd7 || busy !== 1'b1) begin
      failures++;
      $display("FAIL bo_reload frm=%0d busy=%b want 7 1", frm_cnt, busy);
    end
    go_idle();
  endtask

  task automatic test_async_reset();
    start(16'd3, 1'b1);
    for (int i = 0; i < 12; i++) begin
      pos = 1'b1;
      tick();
    end
    checks++;
    if (bit_cnt !== 5'd7 || frm_cnt !== 16'd3) begin
      failures++;
      $display("FAIL rst_pre bit=%0d frm=%0d want 7 3", bit_cnt, frm_cnt);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bit_cnt !== 5'd19 || frm_cnt !== 16'd0 || busy !== 1'b0 ||
        word_done !== 1'b0 || frm_done !== 1'b0 || last_frm !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid bit=%0d frm=%0d busy=%b wd=%b fd=%b lf=%b want 19 0 0 0 0 0",
               bit_cnt, frm_cnt, busy, word_done, frm_done, last_frm);
    end
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (bit_cnt !== 5'd19 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_nocount bit=%0d busy=%b want 19 0", bit_cnt, busy);
    end
    pos = 1'b0;
    bit_en = 1'b0;
    tick();
    start(16'd2, 1'b1);
    pos = 1'b1;
    tick();
    pos = 1'b0;
    checks++;
    if (busy !== 1'b1 || bit_cnt !== 5'd18 || frm_cnt !== 16'd2) begin
      failures++;
      $display("FAIL rst_resume busy=%b bit=%0d frm=%0d want 1 18 2",
               busy, bit_cnt, frm_cnt);
    end
    go_idle();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bit_en = 1'b0;
    frm_en = 1'b0;
    pos = 1'b0;
    neg = 1'b0;
    frm_len = 16'd0;
    tick();
    tick();
    test_reset_init();
    rst = 1'b0;
    tick();
    test_single_word();
    test_multi_word();
    test_abort();
    test_corner_strobes();
    test_bit_only();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
